mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle CPU's MemRead/MemWrite strobes.
//  Unified instruction/data word memory with a configurable access latency.
//  Reports completion with a one-cycle mem_ready pulse and flags illegal accesses.
//  Sits between the control FSM / datapath address mux (IorD) and backing storage.
// PARAMETERS
//  DATA_W       32   data word width
//  ADDR_W       8    word address width
//  DEPTH        256  number of words implemented, 1..2**ADDR_W
//  WAIT_CYCLES  2    extra wait cycles per access, 0..255
// PORTS
//  clk        in   1       clock, rising edge
//  reboot     in   1       reset, asynchronous, active-high
//  mem_read   in   1       read request strobe
//  mem_write  in   1       write request strobe
//  addr       in   ADDR_W  word address, sampled at accept
//  wdata      in   DATA_W  write data, sampled at accept
//  rdata      out  DATA_W  read data, held until next successful read completes
//  mem_ready  out  1       one-cycle completion pulse
//  busy       out  1       high while an access is in flight
//  addr_err   out  1       one-cycle error pulse, coincident with mem_ready
// BEHAVIOUR
//  - One clock, clk; reset reboot is asynchronous and active-high.
//  - Reset values: rdata=0, mem_ready=0, busy=0, addr_err=0, FSM state IDLE,
//    wait counter 0. Memory array contents are not cleared by reboot.
//  - FSM states: IDLE, WAIT, RESP.
//  - IDLE: a request is accepted in cycle N if mem_read or mem_write is high.
//    addr, wdata and the request type are captured at the end of cycle N.
//    Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
//  - WAIT: the counter loads WAIT_CYCLES-1 and decrements. Go to RESP at 0.
//  - RESP: mem_ready=1 for exactly one cycle, then IDLE. No new accept in RESP.
//  - Latency: mem_ready is high in cycle N+1+WAIT_CYCLES.
//  - busy is high from cycle N+1 through the mem_ready cycle inclusive.
//  - Strobes are ignored while busy. An access is neither queued nor merged.
//  - If a strobe is still high in IDLE after RESP, it is a new access.
//    The initiator must deassert its strobe on mem_ready.
//  - Read: rdata updates on the edge entering RESP and is valid during the
//    mem_ready cycle. It holds that value until the next successful read.
//  - Write: mem[addr] is committed on the edge entering RESP. A read accepted
//    after that edge returns the new data. rdata is unchanged by writes.
//  - Error: addr_err=1 with mem_ready, and the array and rdata stay unchanged, when
//    (a) addr >= DEPTH, or
//    (b) mem_read and mem_write are both high at accept.
//  - reboot mid-access (WAIT or RESP): return to IDLE immediately and drop any
//    pending write. No mem_ready is issued for the aborted access.
//  - Address arithmetic is word-indexed only. addr is compared unsigned, no wrap.
// TESTING
//  1. W=2: write 0xDEADBEEF @0x10 at cycle 5 -> busy cycles 6-8, mem_ready only
//     in cycle 8. Then read @0x10 -> rdata=0xDEADBEEF with mem_ready 3 cycles
//     after accept.
//  2. W=0: read accepted at cycle N -> mem_ready and valid rdata in cycle N+1.
//     Back-to-back reads @0,@1 complete in 4 cycles total.
//  3. DEPTH=200: read @0xC8 -> mem_ready=1, addr_err=1, rdata keeps its prior
//     value. Write @0xFF -> no array change (readback @0x3F unaffected).
//  4. mem_read=mem_write=1 @0x04 -> addr_err pulse, mem[4] and rdata unchanged.
//  5. Write 0x1234 @0x20, assert reboot during WAIT -> busy=0 and no mem_ready.
//     A later read @0x20 returns the old value.
//  6. Strobe raised while busy -> ignored, exactly one mem_ready.
//     Strobe held through RESP -> second access accepted in the following IDLE.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU: a unified word memory with a
// fixed access latency, a one-cycle completion pulse and illegal-access flagging.
module mem_responder #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reboot,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_ready,
   output logic              busy,
   output logic              addr_err
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [7:0]      WAIT_L  = 8'(WAIT_CYCLES);
   localparam bit              NO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_r;
   logic [7:0]          cnt_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [DATA_W-1:0]   wdata_r;
   logic                rd_r;
   logic                wr_r;

   logic                accept_s;
   logic                fire_s;
   logic [ADDR_W-1:0]   acc_addr_s;
   logic [DATA_W-1:0]   acc_wdata_s;
   logic                acc_rd_s;
   logic                acc_wr_s;
   logic                err_s;
   logic                mem_we_s;
   logic                rd_ld_s;

   logic [DATA_W-1:0]   mem_r [DEPTH];

   // Access decode: with zero wait the live request completes on its accept edge
   always_comb begin
      accept_s    = (state_r == IDLE) && (mem_read || mem_write);
      fire_s      = 1'b0;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      acc_rd_s    = rd_r;
      acc_wr_s    = wr_r;
      if (NO_WAIT) begin
         fire_s      = accept_s;
         acc_addr_s  = addr;
         acc_wdata_s = wdata;
         acc_rd_s    = mem_read;
         acc_wr_s    = mem_write;
      end else begin
         fire_s = (state_r == WAIT) && (cnt_r == 8'd0);
      end
      err_s    = ({1'b0, acc_addr_s} >= DEPTH_L) || (acc_rd_s && acc_wr_s);
      mem_we_s = fire_s && acc_wr_s && !err_s && !reboot;
      rd_ld_s  = fire_s && acc_rd_s && !err_s;
   end

   // Backing storage: deliberately unreset so reboot leaves contents intact
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[acc_addr_s] <= acc_wdata_s;
      end
   end

   // Control FSM with registered handshake outputs and read data
   always_ff @(posedge clk or posedge reboot) begin
      if (reboot) begin
         state_r   <= IDLE;
         cnt_r     <= 8'd0;
         addr_r    <= {ADDR_W{1'b0}};
         wdata_r   <= {DATA_W{1'b0}};
         rd_r      <= 1'b0;
         wr_r      <= 1'b0;
         rdata     <= {DATA_W{1'b0}};
         mem_ready <= 1'b0;
         busy      <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         mem_ready <= fire_s;
         addr_err  <= fire_s && err_s;
         if (rd_ld_s) begin
            rdata <= mem_r[acc_addr_s];
         end
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  addr_r  <= addr;
                  wdata_r <= wdata;
                  rd_r    <= mem_read;
                  wr_r    <= mem_write;
                  busy    <= 1'b1;
                  if (NO_WAIT) begin
                     state_r <= RESP;
                  end else begin
                     state_r <= WAIT;
                     cnt_r   <= WAIT_L - 8'd1;
                  end
               end
            end
            WAIT: begin
               if (cnt_r == 8'd0) begin
                  state_r <= RESP;
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            RESP: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               cnt_r   <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2-cycle wait with depth 200, zero wait
// with full depth) driven by directed and random accesses against a word-array model.
module tb_mem_responder;

   localparam int W0 = 2;
   localparam int D0 = 200;
   localparam int W1 = 0;
   localparam int D1 = 256;

   logic        clk = 1'b0;
   logic        reboot = 1'b0;
   logic        mrd [2];
   logic        mwr [2];
   logic [7:0]  ad  [2];
   logic [31:0] wd  [2];
   logic [31:0] rdata_o [2];
   logic        ready_o [2];
   logic        busy_o  [2];
   logic        err_o   [2];

   int total = 0;
   int bad   = 0;

   logic [31:0] mm [2][256];
   bit          mv [2][256];
   logic [31:0] er [2];
   bit          rk [2];

   always #5 clk = ~clk;

   mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(D0), .WAIT_CYCLES(W0)) u_dut0 (
      .clk(clk), .reboot(reboot), .mem_read(mrd[0]), .mem_write(mwr[0]),
      .addr(ad[0]), .wdata(wd[0]), .rdata(rdata_o[0]), .mem_ready(ready_o[0]),
      .busy(busy_o[0]), .addr_err(err_o[0])
   );

   mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(D1), .WAIT_CYCLES(W1)) u_dut1 (
      .clk(clk), .reboot(reboot), .mem_read(mrd[1]), .mem_write(mwr[1]),
      .addr(ad[1]), .wdata(wd[1]), .rdata(rdata_o[1]), .mem_ready(ready_o[1]),
      .busy(busy_o[1]), .addr_err(err_o[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete access on instance k; poke toggles strobes while busy,
   // hold leaves the strobes asserted past mem_ready for a follow-on access.
   task automatic access(input int k, input bit rd, input bit wr, input logic [7:0] a,
                         input logic [31:0] d, input bit poke, input bit hold);
      int w;
      int dep;
      bit exp_err;
      w   = (k == 0) ? W0 : W1;
      dep = (k == 0) ? D0 : D1;
      @(negedge clk);
      check($sformatf("dut%0d idle_busy @%h", k, a), 32'(busy_o[k]), 32'd0);
      mrd[k] = rd;
      mwr[k] = wr;
      ad[k]  = a;
      wd[k]  = d;
      exp_err = (int'(a) >= dep) || (rd && wr);
      for (int cyc = 1; cyc <= 1 + w; cyc++) begin
         @(negedge clk);
         check($sformatf("dut%0d busy c%0d @%h", k, cyc, a), 32'(busy_o[k]), 32'd1);
         check($sformatf("dut%0d ready c%0d @%h", k, cyc, a), 32'(ready_o[k]), 32'(cyc == 1 + w));
         if (cyc == 1 + w) begin
            if (!exp_err) begin
               if (wr) begin
                  mm[k][a] = d;
                  mv[k][a] = 1'b1;
               end
               if (rd) begin
                  rk[k] = mv[k][a];
                  er[k] = mm[k][a];
               end
            end
            check($sformatf("dut%0d addr_err @%h", k, a), 32'(err_o[k]), 32'(exp_err));
            if (rk[k]) begin
               check($sformatf("dut%0d rdata @%h", k, a), rdata_o[k], er[k]);
            end
            if (!hold) begin
               mrd[k] = 1'b0;
               mwr[k] = 1'b0;
            end
         end else if (poke) begin
            mrd[k] = 1'($urandom_range(0, 1));
            mwr[k] = !mrd[k];
            ad[k]  = 8'($urandom_range(0, 255));
            wd[k]  = $urandom;
         end else if (!hold) begin
            mrd[k] = 1'b0;
            mwr[k] = 1'b0;
         end
      end
      if (!hold) begin
         @(negedge clk);
         check($sformatf("dut%0d post_ready @%h", k, a), 32'(ready_o[k]), 32'd0);
         check($sformatf("dut%0d post_busy @%h", k, a), 32'(busy_o[k]), 32'd0);
      end
   endtask

   initial begin
      bit rd;
      bit wr;
      int op;
      logic [7:0] a;
      for (int k = 0; k < 2; k++) begin
         mrd[k] = 1'b0;
         mwr[k] = 1'b0;
         ad[k]  = 8'd0;
         wd[k]  = 32'd0;
         er[k]  = 32'd0;
         rk[k]  = 1'b1;
      end

      // reset state
      reboot = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("dut%0d rst rdata", k), rdata_o[k], 32'd0);
         check($sformatf("dut%0d rst ready", k), 32'(ready_o[k]), 32'd0);
         check($sformatf("dut%0d rst busy", k), 32'(busy_o[k]), 32'd0);
         check($sformatf("dut%0d rst err", k), 32'(err_o[k]), 32'd0);
      end
      reboot = 1'b0;

      // write then read back with the 2-cycle wait instance
      access(0, 1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
      access(0, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0);

      // zero wait: back-to-back reads @0,@1 in four cycles
      access(1, 1'b0, 1'b1, 8'h00, 32'h0000_AAAA, 1'b0, 1'b0);
      access(1, 1'b0, 1'b1, 8'h01, 32'h0001_BBBB, 1'b0, 1'b0);
      access(1, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
      access(1, 1'b1, 1'b0, 8'h01, 32'h0, 1'b0, 1'b0);

      // out-of-range addresses on the depth-200 instance
      access(0, 1'b0, 1'b1, 8'h3F, 32'h3F3F_3F3F, 1'b0, 1'b0);
      access(0, 1'b1, 1'b0, 8'hC8, 32'h0, 1'b0, 1'b0);
      access(0, 1'b0, 1'b1, 8'hFF, 32'hBAD0_00FF, 1'b0, 1'b0);
      access(0, 1'b1, 1'b0, 8'h3F, 32'h0, 1'b0, 1'b0);

      // both strobes together
      access(0, 1'b0, 1'b1, 8'h04, 32'h0404_0404, 1'b0, 1'b0);
      access(0, 1'b1, 1'b1, 8'h04, 32'hFFFF_0000, 1'b0, 1'b0);
      access(0, 1'b1, 1'b0, 8'h04, 32'h0, 1'b0, 1'b0);
      access(1, 1'b1, 1'b1, 8'h01, 32'h1111_2222, 1'b0, 1'b0);
      access(1, 1'b1, 1'b0, 8'h01, 32'h0, 1'b0, 1'b0);

      // reboot during WAIT drops the pending write
      access(0, 1'b0, 1'b1, 8'h20, 32'hA5A5_0020, 1'b0, 1'b0);
      @(negedge clk);
      mwr[0] = 1'b1;
      ad[0]  = 8'h20;
      wd[0]  = 32'h0000_1234;
      @(negedge clk);
      mwr[0] = 1'b0;
      check("dut0 abort busy_before", 32'(busy_o[0]), 32'd1);
      #2 reboot = 1'b1;
      #1;
      check("dut0 abort busy_async", 32'(busy_o[0]), 32'd0);
      check("dut0 abort ready_async", 32'(ready_o[0]), 32'd0);
      @(negedge clk);
      reboot = 1'b0;
      for (int k = 0; k < 2; k++) begin
         er[k] = 32'd0;
         rk[k] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("dut0 abort no_ready %0d", i), 32'(ready_o[0]), 32'd0);
      end
      access(0, 1'b1, 1'b0, 8'h20, 32'h0, 1'b0, 1'b0);

      // strobes while busy are ignored; strobe held through RESP is a new access
      access(0, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0);
      access(0, 1'b0, 1'b1, 8'h30, 32'h0000_3030, 1'b0, 1'b1);
      access(0, 1'b1, 1'b0, 8'h30, 32'h0, 1'b0, 1'b0);

      // random traffic against the model
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) begin
            access(k, 1'b0, 1'b1, 8'(i), $urandom, 1'b0, 1'b0);
         end
         for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 9));
            rd = (op < 5) || (op == 9);
            wr = (op >= 5);
            a  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            access(k, rd, wr, a, $urandom, ($urandom_range(0, 3) == 0), 1'b0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
